// File: rtl/apb4_pkg.sv
// Shared definitions for the two-requester APB4 bus arbiter: bus width defaults,
// FSM state encodings and the lock-counter helper.
package apb4_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultAddrWidth = 32;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  function automatic logic [2:0] sat_inc3(input logic [2:0] val);
    return (val == 3'd7) ? val : val + 3'd1;
  endfunction

endpackage

// File: rtl/apb4_rr_picker.sv
// Two-way round-robin owner selection with a bounded lock count that lets the
// current owner keep the bus for up to LOCK_MAX extra grants.
module apb4_rr_picker
  import apb4_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grant_en_i,
  input  logic release_en_i,
  input  logic owner_i,
  input  logic owner_lock_i,
  output logic winner_o
);

  logic       ptr_q, ptr_d;
  logic [2:0] cnt_q, cnt_d;

  // A lone requester always wins; the pointer only breaks ties.
  assign winner_o = (req0_i && req1_i) ? ptr_q : req1_i;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (release_en_i) begin
      if (owner_lock_i && (32'(cnt_q) < LOCK_MAX)) begin
        ptr_d = owner_i;
        cnt_d = sat_inc3(cnt_q);
      end else begin
        ptr_d = ~owner_i;
        cnt_d = '0;
      end
    end else if (grant_en_i && (winner_o != owner_i)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb4_bus_arbiter.sv
// Arbitrates two requesters onto one APB4 master bridge: registers the winning
// command, tracks the transfer and returns the response to its owner.
module apb4_bus_arbiter
  import apb4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned LOCK_MAX   = 4,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  M0_REQ,
  input  logic                  M0_LOCK,
  input  logic                  M0_WRITE,
  input  logic [ADDR_WIDTH-1:0] M0_ADDR,
  input  logic [DATA_WIDTH-1:0] M0_WDATA,
  input  logic [STRB_WIDTH-1:0] M0_STRB,
  output logic                  M0_GNT,
  output logic                  M0_DONE,
  output logic [DATA_WIDTH-1:0] M0_RDATA,
  output logic                  M0_SLVERR,
  input  logic                  M1_REQ,
  input  logic                  M1_LOCK,
  input  logic                  M1_WRITE,
  input  logic [ADDR_WIDTH-1:0] M1_ADDR,
  input  logic [DATA_WIDTH-1:0] M1_WDATA,
  input  logic [STRB_WIDTH-1:0] M1_STRB,
  output logic                  M1_GNT,
  output logic                  M1_DONE,
  output logic [DATA_WIDTH-1:0] M1_RDATA,
  output logic                  M1_SLVERR,
  output logic                  TRANSFER,
  output logic                  WRITE,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] STRB,
  input  logic                  READY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  SLVERR,
  output logic                  OWNER
);

  logic [1:0] state_q, state_d;
  logic       owner_q;
  logic       any_req;
  logic       grant;
  logic       capture;
  logic       winner;
  logic       busy;

  assign any_req = M0_REQ | M1_REQ;
  assign grant   = (state_q == StIdle) && any_req;
  assign capture = (state_q == StWait) && READY;

  apb4_rr_picker #(
    .LOCK_MAX (LOCK_MAX)
  ) u_picker (
    .clk_i        (PCLK),
    .rst_i        (PRESET),
    .req0_i       (M0_REQ),
    .req1_i       (M1_REQ),
    .grant_en_i   (grant),
    .release_en_i (state_q == StResp),
    .owner_i      (owner_q),
    .owner_lock_i (owner_q ? M1_LOCK : M0_LOCK),
    .winner_o     (winner)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (READY) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      WRITE     <= 1'b0;
      ADDR      <= '0;
      WDATA     <= '0;
      STRB      <= '0;
      M0_RDATA  <= '0;
      M0_SLVERR <= 1'b0;
      M1_RDATA  <= '0;
      M1_SLVERR <= 1'b0;
    end else begin
      state_q <= state_d;
      // Command is frozen from ISSUE until the next grant.
      if (grant) begin
        owner_q <= winner;
        WRITE   <= winner ? M1_WRITE : M0_WRITE;
        ADDR    <= winner ? M1_ADDR  : M0_ADDR;
        WDATA   <= winner ? M1_WDATA : M0_WDATA;
        STRB    <= winner ? M1_STRB  : M0_STRB;
      end
      if (capture && !owner_q) begin
        M0_RDATA  <= RDATA;
        M0_SLVERR <= SLVERR;
      end
      if (capture && owner_q) begin
        M1_RDATA  <= RDATA;
        M1_SLVERR <= SLVERR;
      end
    end
  end

  assign busy     = (state_q != StIdle);
  assign TRANSFER = (state_q == StIssue);
  assign M0_GNT   = busy && !owner_q;
  assign M1_GNT   = busy && owner_q;
  assign M0_DONE  = (state_q == StResp) && !owner_q;
  assign M1_DONE  = (state_q == StResp) && owner_q;
  assign OWNER    = owner_q;

endmodule
